// File: rtl/fifo0_rr_arbiter.sv
// Round-robin credit arbiter for a token-only FIFO: four requesters share p1depth credits.
// Optional sticky overflow error: define FIFO0_ARB_ERRCHK_EN (default build ties ERR low).
module fifo0_rr_arbiter #(
   parameter int p1depth      = 2,
   parameter int p2cntr_width = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    CLR,
   input  logic [3:0]              REQ,
   input  logic                    RET,
   output logic [3:0]              GNT,
   output logic                    AVAIL,
   output logic                    IDLE,
   output logic [p2cntr_width-1:0] CREDITS,
   output logic                    ERR
);

   localparam logic [p2cntr_width-1:0] DEPTH = p2cntr_width'(p1depth);

   logic [p2cntr_width-1:0] cnt_q, cnt_d;
   logic [1:0]              ptr_q, ptr_d;
   logic                    avail_q, idle_q;
   logic [1:0]              gsel;
   logic [1:0]              idx;
   logic                    found;
   logic                    gnt_vld;

   // Search order starts at the pointer and wraps through all four requesters.
   always_comb begin
      found = 1'b0;
      gsel  = 2'd0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && REQ[idx]) begin
            found = 1'b1;
            gsel  = idx;
         end
      end
   end

   assign gnt_vld = found && avail_q && !RST && !CLR;
   assign GNT     = gnt_vld ? (4'b0001 << gsel) : 4'b0000;

   // A credit returned this cycle is only counted, never granted, until the next cycle.
   always_comb begin
      cnt_d = cnt_q;
      ptr_d = ptr_q;
      if (gnt_vld) begin
         ptr_d = gsel + 2'd1;
      end
      if (gnt_vld && !RET) begin
         cnt_d = cnt_q - 1'b1;
      end else if (!gnt_vld && RET && (cnt_q != DEPTH)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         cnt_q   <= DEPTH;
         ptr_q   <= 2'd0;
         avail_q <= 1'b1;
         idle_q  <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         avail_q <= (cnt_d != '0);
         idle_q  <= (cnt_d == DEPTH);
      end
   end

   assign AVAIL   = avail_q;
   assign IDLE    = idle_q;
   assign CREDITS = cnt_q;

`ifdef FIFO0_ARB_ERRCHK_EN
   logic err_q;
   logic ovf;

   // Overflow: a return with every credit already home and nothing consumed.
   assign ovf = RET && !gnt_vld && !RST && !CLR && (cnt_q == DEPTH);

   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= 1'b0;
      end else if (ovf) begin
         err_q <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (ovf) begin
         $warning("%m: credit returned while pool full, ignored");
      end
   end
`endif

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_fifo0_rr_arbiter.sv
// Scoreboard bench for fifo0_rr_arbiter: a behavioural credit/pointer model pushes
// expected grant and next-state records, which each scenario pops and compares.
module tb_fifo0_rr_arbiter;

`ifdef FIFO0_ARB_ERRCHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif
   localparam logic [1:0] DEPTH = 2'd2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CLR = 1'b0;
   logic [3:0] REQ = 4'b0;
   logic       RET = 1'b0;
   logic [3:0] GNT;
   logic       AVAIL, IDLE, ERR;
   logic [1:0] CREDITS;

   fifo0_rr_arbiter #(.p1depth(2), .p2cntr_width(2)) dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .REQ(REQ), .RET(RET),
      .GNT(GNT), .AVAIL(AVAIL), .IDLE(IDLE), .CREDITS(CREDITS), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] gnt;
      logic [4:0] st;   // {credits, avail, idle, err}
   } exp_t;

   exp_t       sbq[$];
   exp_t       e;
   logic [3:0] obs_gnt;
   logic [4:0] obs_st;
   int         n_vec = 0;
   int         n_err = 0;

   logic [1:0] m_cnt = DEPTH;
   logic [1:0] m_ptr = 2'd0;
   logic       m_err = 1'b0;

   // Drive one cycle {rst,clr,ret,req}, push the model's expectation, capture DUT outputs.
   task automatic cycle(input logic [6:0] v);
      logic [3:0] g;
      logic [1:0] p;
      logic       rst, clr, ret;
      exp_t       x;
      rst = v[6]; clr = v[5]; ret = v[4];
      @(negedge CLK);
      RST = rst; CLR = clr; RET = ret; REQ = v[3:0];
      g = 4'b0;
      if (!rst && !clr && m_cnt != 2'd0) begin
         for (int k = 3; k >= 0; k--) begin
            p = m_ptr + 2'(k);
            if (v[p]) g = 4'b0001 << p;
         end
      end
      if (rst) begin
         m_cnt = DEPTH; m_ptr = 2'd0; m_err = 1'b0;
      end else if (clr) begin
         m_cnt = DEPTH; m_ptr = 2'd0;
      end else begin
         for (int k = 0; k < 4; k++) if (g[k]) m_ptr = 2'(k + 1);
         if (g != 0 && !ret) m_cnt = m_cnt - 2'd1;
         else if (g == 0 && ret) begin
            if (m_cnt == DEPTH) m_err = m_err | ERRCHK;
            else m_cnt = m_cnt + 2'd1;
         end
      end
      x.gnt = g;
      x.st  = {m_cnt, m_cnt != 2'd0, m_cnt == DEPTH, m_err};
      sbq.push_back(x);
      #1;
      obs_gnt = GNT;
      @(posedge CLK);
      #1;
      obs_st = {CREDITS, AVAIL, IDLE, ERR};
   endtask

   task automatic test_reset();
      logic [6:0] v[2] = '{7'b1000000, 7'b1001111};
      foreach (v[i]) begin
         cycle(v[i]);
         e = sbq.pop_front();
         n_vec++;
         if (obs_gnt !== e.gnt) begin n_err++; $display("FAIL reset_gnt[%0d] got %b want %b", i, obs_gnt, e.gnt); end
         n_vec++;
         if (obs_st !== e.st) begin n_err++; $display("FAIL reset_state[%0d] got %b want %b", i, obs_st, e.st); end
      end
   endtask

   // Drain both credits with all requesters active.
   task automatic test_drain();
      logic [6:0] v[4] = '{7'b1000000, 7'b0001111, 7'b0001111, 7'b0001111};
      foreach (v[i]) begin
         cycle(v[i]);
         e = sbq.pop_front();
         n_vec++;
         if (obs_gnt !== e.gnt) begin n_err++; $display("FAIL drain_gnt[%0d] got %b want %b", i, obs_gnt, e.gnt); end
         n_vec++;
         if (obs_st !== e.st) begin n_err++; $display("FAIL drain_state[%0d] got %b want %b", i, obs_st, e.st); end
      end
      n_vec++;
      if (CREDITS !== 2'd0 || AVAIL !== 1'b0) begin n_err++; $display("FAIL drain_empty got %0d/%b want 0/0", CREDITS, AVAIL); end
   endtask

   // Return at zero credits is not grantable in its own cycle; then grant with return.
   task automatic test_ret_paths();
      logic [6:0] v[5] = '{7'b0010100, 7'b0000100, 7'b0010000, 7'b0011000, 7'b0001111};
      foreach (v[i]) begin
         cycle(v[i]);
         e = sbq.pop_front();
         n_vec++;
         if (obs_gnt !== e.gnt) begin n_err++; $display("FAIL ret_gnt[%0d] got %b want %b", i, obs_gnt, e.gnt); end
         n_vec++;
         if (obs_st !== e.st) begin n_err++; $display("FAIL ret_state[%0d] got %b want %b", i, obs_st, e.st); end
      end
   endtask

   // Overflow return: ERR sticks through CLR, drops on RST (stays 0 without the option).
   task automatic test_overflow();
      logic [6:0] v[5] = '{7'b1000000, 7'b0010000, 7'b0100000, 7'b0000000, 7'b1000000};
      foreach (v[i]) begin
         cycle(v[i]);
         e = sbq.pop_front();
         n_vec++;
         if (obs_gnt !== e.gnt) begin n_err++; $display("FAIL ovf_gnt[%0d] got %b want %b", i, obs_gnt, e.gnt); end
         n_vec++;
         if (obs_st !== e.st) begin n_err++; $display("FAIL ovf_state[%0d] got %b want %b", i, obs_st, e.st); end
      end
   endtask

   // Pointer at 2 with REQ=0011 must wrap to requester 0, then 1.
   task automatic test_ptr_wrap();
      logic [6:0] v[5] = '{7'b1000000, 7'b0000010, 7'b0010000, 7'b0000011, 7'b0000011};
      foreach (v[i]) begin
         cycle(v[i]);
         e = sbq.pop_front();
         n_vec++;
         if (obs_gnt !== e.gnt) begin n_err++; $display("FAIL wrap_gnt[%0d] got %b want %b", i, obs_gnt, e.gnt); end
         n_vec++;
         if (obs_st !== e.st) begin n_err++; $display("FAIL wrap_state[%0d] got %b want %b", i, obs_st, e.st); end
      end
   endtask

   // Clear at ptr=3, cnt=0 together with requests and a return.
   task automatic test_clr();
      logic [6:0] v[5] = '{7'b1000000, 7'b0000100, 7'b0000100, 7'b0111111, 7'b0001111};
      foreach (v[i]) begin
         cycle(v[i]);
         e = sbq.pop_front();
         n_vec++;
         if (obs_gnt !== e.gnt) begin n_err++; $display("FAIL clr_gnt[%0d] got %b want %b", i, obs_gnt, e.gnt); end
         n_vec++;
         if (obs_st !== e.st) begin n_err++; $display("FAIL clr_state[%0d] got %b want %b", i, obs_st, e.st); end
      end
   endtask

   task automatic test_random();
      logic [6:0] v;
      for (int i = 0; i < 300; i++) begin
         v[6]   = ($urandom_range(0, 40) == 0);
         v[5]   = ($urandom_range(0, 30) == 0);
         v[4]   = ($urandom_range(0, 2) == 0);
         v[3:0] = 4'($urandom);
         cycle(v);
         e = sbq.pop_front();
         n_vec++;
         if (obs_gnt !== e.gnt) begin n_err++; $display("FAIL rand_gnt[%0d] got %b want %b", i, obs_gnt, e.gnt); end
         n_vec++;
         if (obs_st !== e.st) begin n_err++; $display("FAIL rand_state[%0d] got %b want %b", i, obs_st, e.st); end
      end
   endtask

   initial begin
      test_reset();
      test_drain();
      test_ret_paths();
      test_overflow();
      test_ptr_wrap();
      test_clr();
      test_random();
      n_vec++;
      if (sbq.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d want 0", sbq.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
